// File: rtl/read_op_scheduler_if.sv
// Host request/response and flash pin bundle for read_op_scheduler.
interface read_op_scheduler_if;
  logic [2:0]  req;
  logic [2:0]  ack;
  logic        err;
  logic        busy;
  logic [31:0] rd_data;
  logic [7:0]  io_out;
  logic        io_oe;
  logic [7:0]  io_in;
  logic        ce_n;
  logic        cle;
  logic        ale;
  logic        we_n;
  logic        re_n;
  logic        rb_n;

  // Scheduler side: drives flash strobes and host responses.
  modport master (
    input  req, io_in, rb_n,
    output ack, err, busy, rd_data, io_out, io_oe, ce_n, cle, ale, we_n, re_n
  );

  // Host/flash side: drives requests and flash responses.
  modport slave (
    output req, io_in, rb_n,
    input  ack, err, busy, rd_data, io_out, io_oe, ce_n, cle, ale, we_n, re_n
  );
endinterface

// File: rtl/read_op_scheduler.sv
// Schedules RESET / READ ID / READ STATUS operations onto a NAND-style
// flash bus: command cycle, optional address cycle, tWHR wait, then either
// data reads or a ready/busy wait. All outputs are registered.
module read_op_scheduler #(
  parameter int unsigned HALF_CYC   = 2,
  parameter int unsigned WHR_CYC    = 12,
  parameter int unsigned RB_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  read_op_scheduler_if.master   bus
);

  localparam int unsigned BUS_CYC = 2 * HALF_CYC;
  localparam int unsigned MAX_A   = (BUS_CYC > WHR_CYC) ? BUS_CYC : WHR_CYC;
  localparam int unsigned CMAX    = (MAX_A > RB_TIMEOUT) ? MAX_A : RB_TIMEOUT;
  localparam int unsigned CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HALF     = CW'(HALF_CYC);
  localparam logic [CW-1:0] LOW_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] BUS_LAST = CW'(BUS_CYC - 1);
  localparam logic [CW-1:0] WHR_LAST = CW'(WHR_CYC - 1);
  localparam logic [CW-1:0] RB_LAST  = CW'(RB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WHR, S_READ, S_WAIT_RB, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cyc_q, cyc_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    pend_q, pend_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [2:0]    ack_q, ack_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [7:0]    io_out_q, io_out_d;
  logic          io_oe_q, io_oe_d;
  logic          ce_n_q, ce_n_d;
  logic          cle_q, cle_d;
  logic          ale_q, ale_d;
  logic          we_n_q, we_n_d;
  logic          re_n_q, re_n_d;
  logic          rb_s1_q, rb_s2_q;

  logic [2:0]    clr;
  logic          timeout;
  logic          low_ph;
  logic [1:0]    last_cyc;
  logic [7:0]    opcode;

  // Next-state, counters, capture and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    grant_d  = grant_q;
    buf_d    = buf_q;
    clr      = '0;
    timeout  = 1'b0;
    last_cyc = grant_q[1] ? 2'd3 : 2'd0;

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          grant_d = pend_q[0] ? 3'b001 : (pend_q[1] ? 3'b010 : 3'b100);
          clr     = grant_d;
          buf_d   = '0;
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cnt_q == BUS_LAST) begin
          cnt_d   = '0;
          state_d = grant_q[1] ? S_ADDR : S_WHR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ADDR: begin
        if (cnt_q == BUS_LAST) begin
          cnt_d   = '0;
          state_d = S_WHR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WHR: begin
        if (cnt_q == WHR_LAST) begin
          cnt_d   = '0;
          state_d = grant_q[0] ? S_WAIT_RB : S_READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        if (cnt_q == LOW_LAST) begin
          buf_d[{cyc_q, 3'b000} +: 8] = bus.io_in;
        end
        if (cnt_q == BUS_LAST) begin
          cnt_d = '0;
          if (cyc_q == last_cyc) begin
            state_d = S_DONE;
          end else begin
            cyc_d = cyc_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_RB: begin
        if (rb_s2_q) begin
          state_d = S_DONE;
        end else if (cnt_q == RB_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new pulse wins over the grant-clear of the same clock.
    pend_d = (pend_q & ~clr) | bus.req;

    opcode = grant_d[0] ? 8'hFF : (grant_d[1] ? 8'h90 : 8'h70);
    low_ph = (cnt_d < HALF);

    // Outputs are derived from next-state values so they line up with the state.
    ce_n_d    = (state_d == S_IDLE);
    cle_d     = (state_d == S_CMD);
    ale_d     = (state_d == S_ADDR);
    io_oe_d   = (state_d == S_CMD) || (state_d == S_ADDR);
    io_out_d  = (state_d == S_CMD) ? opcode : 8'h00;
    we_n_d    = !(io_oe_d && low_ph);
    re_n_d    = !((state_d == S_READ) && low_ph);
    ack_d     = (state_d == S_DONE) ? grant_d : 3'b000;
    err_d     = timeout;
    rd_data_d = (state_d == S_DONE) ? buf_d : rd_data_q;
    // IDLE with work already pending counts as busy, so queued ops show no gap.
    busy_d    = (state_d != S_IDLE) || (|pend_d);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cyc_q     <= '0;
      grant_q   <= '0;
      pend_q    <= '0;
      buf_q     <= '0;
      rd_data_q <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      io_out_q  <= '0;
      io_oe_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      cle_q     <= 1'b0;
      ale_q     <= 1'b0;
      we_n_q    <= 1'b1;
      re_n_q    <= 1'b1;
      rb_s1_q   <= 1'b0;
      rb_s2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      grant_q   <= grant_d;
      pend_q    <= pend_d;
      buf_q     <= buf_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
      ce_n_q    <= ce_n_d;
      cle_q     <= cle_d;
      ale_q     <= ale_d;
      we_n_q    <= we_n_d;
      re_n_q    <= re_n_d;
      rb_s1_q   <= bus.rb_n;
      rb_s2_q   <= rb_s1_q;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_data_q;
  assign bus.io_out  = io_out_q;
  assign bus.io_oe   = io_oe_q;
  assign bus.ce_n    = ce_n_q;
  assign bus.cle     = cle_q;
  assign bus.ale     = ale_q;
  assign bus.we_n    = we_n_q;
  assign bus.re_n    = re_n_q;

endmodule

// File: tb/tb_read_op_scheduler.sv
// Directed bench for read_op_scheduler (HALF_CYC=2, WHR_CYC=12, RB_TIMEOUT=100).
module tb_read_op_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  read_op_scheduler_if bus();

  read_op_scheduler #(
    .HALF_CYC  (2),
    .WHR_CYC   (12),
    .RB_TIMEOUT(100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Flash data model: each re_n fall presents the next byte of the table.
  logic [7:0]  model [4];
  int unsigned fall_cnt = 0;
  int unsigned base = 0;
  logic [1:0]  sel;
  always @(negedge bus.re_n) fall_cnt++;
  assign sel        = 2'(fall_cnt - base - 1);
  assign bus.io_in  = model[sel];

  localparam logic [50:0] RST_OUTS = {3'b000, 1'b0, 1'b0, 32'h0, 8'h00,
                                      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic [50:0] outs();
    return {bus.ack, bus.err, bus.busy, bus.rd_data, bus.io_out,
            bus.io_oe, bus.ce_n, bus.cle, bus.ale, bus.we_n, bus.re_n};
  endfunction

  task automatic test_reset();
    reset = 1'b1; bus.req = '0; bus.rb_n = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (outs() !== RST_OUTS) begin
      miscompares++;
      $display("FAIL reset_outs got=%h exp=%h", outs(), RST_OUTS);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_id();
    int lat = 0, cle_n = 0, ale_n = 0, re_lo = 0;
    logic done = 1'b0;
    model[0] = 8'hEC; model[1] = 8'hD3; model[2] = 8'h51; model[3] = 8'h95;
    base = fall_cnt;
    @(negedge clk); bus.req = 3'b010;
    while (!done && lat < 200) begin
      @(negedge clk); bus.req = '0; lat++;
      if (!bus.we_n && bus.cle && bus.io_oe && bus.io_out == 8'h90) cle_n++;
      if (!bus.we_n && bus.ale && bus.io_oe && bus.io_out == 8'h00) ale_n++;
      if (!bus.re_n) re_lo++;
      if (bus.ack != 3'b000) done = 1'b1;
    end
    vectors++;
    if (lat !== 38) begin miscompares++; $display("FAIL rid_latency got=%0d exp=38", lat); end
    vectors++;
    if (bus.ack !== 3'b010 || bus.err !== 1'b0) begin
      miscompares++; $display("FAIL rid_ack got=%b/%b exp=010/0", bus.ack, bus.err);
    end
    vectors++;
    if (bus.rd_data !== 32'h9551D3EC) begin
      miscompares++; $display("FAIL rid_data got=%h exp=9551d3ec", bus.rd_data);
    end
    vectors++;
    if (cle_n !== 2 || ale_n !== 2 || re_lo !== 8) begin
      miscompares++;
      $display("FAIL rid_bus got cle=%0d ale=%0d re=%0d exp 2/2/8", cle_n, ale_n, re_lo);
    end
    @(negedge clk);
    vectors++;
    if (bus.ack !== 3'b000 || bus.rd_data !== 32'h9551D3EC) begin
      miscompares++; $display("FAIL rid_hold got ack=%b data=%h", bus.ack, bus.rd_data);
    end
  endtask

  task automatic test_read_status();
    int lat = 0, ale_n = 0, re_lo = 0;
    logic done = 1'b0;
    model[0] = 8'hE0;
    base = fall_cnt;
    @(negedge clk); bus.req = 3'b100;
    while (!done && lat < 200) begin
      @(negedge clk); bus.req = '0; lat++;
      if (bus.ale) ale_n++;
      if (!bus.re_n) re_lo++;
      if (bus.ack != 3'b000) done = 1'b1;
    end
    vectors++;
    if (lat !== 22 || bus.ack !== 3'b100) begin
      miscompares++; $display("FAIL rs_latency got=%0d ack=%b exp=22/100", lat, bus.ack);
    end
    vectors++;
    if (bus.rd_data !== 32'h000000E0) begin
      miscompares++; $display("FAIL rs_data got=%h exp=000000e0", bus.rd_data);
    end
    vectors++;
    if (ale_n !== 0 || re_lo !== 2) begin
      miscompares++; $display("FAIL rs_bus got ale=%0d re=%0d exp 0/2", ale_n, re_lo);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_three();
    int lat = 0, n = 0, busy_gaps = 0;
    int t [3];
    logic [2:0] a [3];
    logic [31:0] rd_after_reset = 'x;
    model[0] = 8'h11; model[1] = 8'h22; model[2] = 8'h33; model[3] = 8'h44;
    base = fall_cnt;
    @(negedge clk); bus.req = 3'b111;
    while (lat < 140) begin
      @(negedge clk); bus.req = '0; lat++;
      if (n < 3 && bus.busy !== 1'b1) busy_gaps++;
      if (bus.ack != 3'b000) begin
        if (n < 3) begin t[n] = lat; a[n] = bus.ack; end
        if (n == 0) rd_after_reset = bus.rd_data;
        n++;
      end
    end
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL all3_count got=%0d exp=3", n); end
    vectors++;
    if (a[0] !== 3'b001 || a[1] !== 3'b010 || a[2] !== 3'b100) begin
      miscompares++; $display("FAIL all3_order got=%b,%b,%b exp=001,010,100", a[0], a[1], a[2]);
    end
    vectors++;
    if (t[0] !== 19 || t[1] !== 57 || t[2] !== 79) begin
      miscompares++; $display("FAIL all3_times got=%0d,%0d,%0d exp=19,57,79", t[0], t[1], t[2]);
    end
    vectors++;
    if (busy_gaps !== 0) begin miscompares++; $display("FAIL all3_busy got gaps=%0d exp=0", busy_gaps); end
    vectors++;
    if (rd_after_reset !== 32'h0 || bus.rd_data !== 32'h00000011) begin
      miscompares++; $display("FAIL all3_data got=%h,%h exp=0,11", rd_after_reset, bus.rd_data);
    end
  endtask

  task automatic test_rb_wait(input logic rise, input int exp_lat, input logic exp_err);
    int lat = 0;
    logic done = 1'b0;
    bus.rb_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.req = 3'b001;
    while (!done && lat < 300) begin
      @(negedge clk); bus.req = '0; lat++;
      if (rise && lat == 50) bus.rb_n = 1'b1;
      if (bus.ack != 3'b000) done = 1'b1;
    end
    vectors++;
    if (lat !== exp_lat || bus.ack !== 3'b001 || bus.err !== exp_err) begin
      miscompares++;
      $display("FAIL rb_wait got lat=%0d ack=%b err=%b exp=%0d/001/%b", lat, bus.ack, bus.err, exp_lat, exp_err);
    end
    vectors++;
    if (bus.rd_data !== 32'h0) begin miscompares++; $display("FAIL rb_data got=%h exp=0", bus.rd_data); end
    bus.rb_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat = 0, acks = 0;
    logic done = 1'b0;
    model[0] = 8'hA1; model[1] = 8'hB2; model[2] = 8'hC3; model[3] = 8'hD4;
    base = fall_cnt;
    @(negedge clk); bus.req = 3'b010;
    while ((fall_cnt - base) < 3 && lat < 200) begin
      @(negedge clk); bus.req = '0; lat++;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (outs() !== RST_OUTS) begin
      miscompares++; $display("FAIL midreset_outs got=%h exp=%h", outs(), RST_OUTS);
    end
    @(negedge clk); reset = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bus.ack != 3'b000 || bus.busy) acks++;
    end
    vectors++;
    if (acks !== 0) begin miscompares++; $display("FAIL midreset_noack got=%0d exp=0", acks); end
    model[0] = 8'h5A; model[1] = 8'h6B; model[2] = 8'h7C; model[3] = 8'h8D;
    base = fall_cnt;
    lat = 0;
    bus.req = 3'b010;
    while (!done && lat < 200) begin
      @(negedge clk); bus.req = '0; lat++;
      if (bus.ack != 3'b000) done = 1'b1;
    end
    vectors++;
    if (lat !== 38 || bus.ack !== 3'b010 || bus.rd_data !== 32'h8D7C6B5A) begin
      miscompares++;
      $display("FAIL midreset_retry got lat=%0d ack=%b data=%h exp=38/010/8d7c6b5a", lat, bus.ack, bus.rd_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat = 0, n = 0;
    int t [2];
    model[0] = 8'h01; model[1] = 8'h02; model[2] = 8'h03; model[3] = 8'h04;
    base = fall_cnt;
    t[0] = 0; t[1] = 0;
    @(negedge clk); bus.req = 3'b010;
    while (lat < 150) begin
      @(negedge clk); bus.req = '0; lat++;
      if (lat == 5 || lat == 12) bus.req = 3'b010;
      if (bus.ack[1]) begin
        if (n < 2) t[n] = lat;
        n++;
      end
    end
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL b2b_count got=%0d exp=2", n); end
    vectors++;
    if (t[0] !== 38 || t[1] !== 76) begin
      miscompares++; $display("FAIL b2b_times got=%0d,%0d exp=38,76", t[0], t[1]);
    end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_read_status();
    test_all_three();
    test_rb_wait(1'b0, 118, 1'b1);
    test_rb_wait(1'b1, 53, 1'b0);
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
